// File: rtl/obstacle_engine.sv
// Parametrised square-obstacle generator: per-slot motion on frame ticks plus a registered pixel hit vector.
// Optional macro OBSTACLE_BOUNCE_EN: moving slots reverse at the playfield limits instead of respawning.

module obstacleSlot #(
    parameter int BLOCK_SIZE = 50,
    parameter int X_MAX      = 640,
    parameter int Y_MAX      = 480,
    parameter int SPEED_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               wr,
    input  logic [1:0]         cfgMode,
    input  logic [9:0]         cfgX,
    input  logic [8:0]         cfgY,
    input  logic [SPEED_W-1:0] cfgSpeed,
    input  logic [9:0]         xCount,
    input  logic [9:0]         yCount,
    output logic               hit
);
    typedef struct packed {
        logic [1:0]         mode;
        logic [9:0]         x;
        logic [8:0]         y;
        logic [SPEED_W-1:0] speed;
    } slotState_t;

    localparam logic [10:0] X_LIM = 11'(X_MAX - BLOCK_SIZE);
    localparam logic [9:0]  Y_LIM = 10'(Y_MAX - BLOCK_SIZE);

    slotState_t st, nxt;
    logic [9:0] ySum;
`ifdef OBSTACLE_BOUNCE_EN
    logic       dir, dirNxt;
    logic [10:0] xSum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
`ifdef OBSTACLE_BOUNCE_EN
            dir <= 1'b0;
`endif
        end else if (wr) begin
            st <= '{mode: cfgMode, x: cfgX, y: cfgY, speed: cfgSpeed};
`ifdef OBSTACLE_BOUNCE_EN
            dir <= 1'b0;
`endif
        end else if (tick) begin
            st <= nxt;
`ifdef OBSTACLE_BOUNCE_EN
            dir <= dirNxt;
`endif
        end
    end

    always_comb begin
        nxt  = st;
        ySum = {1'b0, st.y} + 10'(st.speed);
`ifdef OBSTACLE_BOUNCE_EN
        dirNxt = dir;
        xSum   = {1'b0, st.x} + 11'(st.speed);
`endif
        case (st.mode)
            2'd1: begin
`ifdef OBSTACLE_BOUNCE_EN
                if (!dir) begin
                    if (ySum > Y_LIM) begin
                        nxt.y  = Y_LIM[8:0];
                        dirNxt = 1'b1;
                    end else begin
                        nxt.y = ySum[8:0];
                    end
                end else if ({1'b0, st.y} < 10'(st.speed)) begin
                    nxt.y  = '0;
                    dirNxt = 1'b0;
                end else begin
                    nxt.y = st.y - 9'(st.speed);
                end
`else
                nxt.y = (ySum > Y_LIM) ? 9'd0 : ySum[8:0];
`endif
            end
            2'd2: begin
`ifdef OBSTACLE_BOUNCE_EN
                if (!dir) begin
                    if (st.x < 10'(st.speed)) begin
                        nxt.x  = '0;
                        dirNxt = 1'b1;
                    end else begin
                        nxt.x = st.x - 10'(st.speed);
                    end
                end else if (xSum > X_LIM) begin
                    nxt.x  = X_LIM[9:0];
                    dirNxt = 1'b0;
                end else begin
                    nxt.x = xSum[9:0];
                end
`else
                // Respawn at the right edge rather than wrapping below zero.
                nxt.x = (st.x < 10'(st.speed)) ? X_LIM[9:0] : st.x - 10'(st.speed);
`endif
            end
            default: ;
        endcase
    end

    // Exclusive bounds at 11 bits so x/y + BLOCK_SIZE cannot wrap.
    logic [10:0] xe, ye, x0, y0;
    always_comb begin
        xe  = {1'b0, xCount};
        ye  = {1'b0, yCount};
        x0  = {1'b0, st.x};
        y0  = {2'b0, st.y};
        hit = (st.mode != 2'd0)
            && (xe > x0) && (xe < x0 + 11'(BLOCK_SIZE))
            && (ye > y0) && (ye < y0 + 11'(BLOCK_SIZE));
    end
endmodule

module obstacle_engine #(
    parameter  int NUM_BLOCKS = 8,
    parameter  int BLOCK_SIZE = 50,
    parameter  int X_MAX      = 640,
    parameter  int Y_MAX      = 480,
    parameter  int SPEED_W    = 4,
    localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  update,
    input  logic [9:0]            xCount,
    input  logic [9:0]            yCount,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [1:0]            cfg_mode,
    input  logic [9:0]            cfg_x,
    input  logic [8:0]            cfg_y,
    input  logic [SPEED_W-1:0]    cfg_speed,
    output logic [NUM_BLOCKS-1:0] blocks,
    output logic                  any_block,
    output logic [IDX_W-1:0]      hit_idx
);
    logic update_d, tick, inRange;
    logic [NUM_BLOCKS-1:0] hitVec;
    logic [IDX_W-1:0]      hitIdx;

    assign tick    = update & ~update_d;
    assign inRange = {1'b0, cfg_idx} < (IDX_W+1)'(NUM_BLOCKS);

    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : gSlot
        obstacleSlot #(
            .BLOCK_SIZE(BLOCK_SIZE), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SPEED_W(SPEED_W)
        ) uSlot (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .wr      (cfg_we && inRange && (cfg_idx == IDX_W'(g))),
            .cfgMode (cfg_mode),
            .cfgX    (cfg_x),
            .cfgY    (cfg_y),
            .cfgSpeed(cfg_speed),
            .xCount  (xCount),
            .yCount  (yCount),
            .hit     (hitVec[g])
        );
    end

    // Lowest set index wins; scan from the top so the last assignment is the lowest.
    always_comb begin
        hitIdx = '0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--)
            if (hitVec[i]) hitIdx = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update_d  <= 1'b0;
            blocks    <= '0;
            any_block <= 1'b0;
            hit_idx   <= '0;
        end else begin
            update_d  <= update;
            blocks    <= hitVec;
            any_block <= |hitVec;
            hit_idx   <= hitIdx;
        end
    end
endmodule

// File: tb/tb_obstacle_engine.sv
// Self-checking bench for obstacle_engine: constant vectors, corner sequences and a randomized run vs. a slot model.
module tb_obstacle_engine;
    localparam int NB = 8, BS = 50, XM = 640, YM = 480, SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, update, cfg_we;
    logic [9:0]    xCount, yCount, cfg_x;
    logic [2:0]    cfg_idx;
    logic [1:0]    cfg_mode;
    logic [8:0]    cfg_y;
    logic [SW-1:0] cfg_speed;
    logic [NB-1:0] blocks;
    logic          any_block;
    logic [2:0]    hit_idx;

    obstacle_engine #(.NUM_BLOCKS(NB), .BLOCK_SIZE(BS), .X_MAX(XM), .Y_MAX(YM), .SPEED_W(SW)) dut (
        .clk(clk), .rst(rst), .update(update), .xCount(xCount), .yCount(yCount),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_x(cfg_x),
        .cfg_y(cfg_y), .cfg_speed(cfg_speed), .blocks(blocks), .any_block(any_block),
        .hit_idx(hit_idx)
    );

    int nCmp = 0, nBad = 0;
    int mMode[NB], mX[NB], mY[NB], mSp[NB], mDir[NB];

    typedef struct { int px; int py; logic [NB-1:0] expB; } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int expBlocks(input int px, input int py);
        int r = 0;
        for (int i = 0; i < NB; i++)
            if (mMode[i] != 0 && px > mX[i] && px < mX[i] + BS && py > mY[i] && py < mY[i] + BS)
                r |= (1 << i);
        return r;
    endfunction

    function automatic int lowestBit(input int v);
        for (int i = 0; i < NB; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NB; i++) begin
            mMode[i] = 0; mX[i] = 0; mY[i] = 0; mSp[i] = 0; mDir[i] = 0;
        end
    endfunction

    function automatic void modelStep(input int skip);
        int lim_x = XM - BS, lim_y = YM - BS;
        for (int i = 0; i < NB; i++) begin
            if (i == skip) continue;
`ifdef OBSTACLE_BOUNCE_EN
            if (mMode[i] == 1) begin
                if (mDir[i] == 0) begin
                    if (mY[i] + mSp[i] > lim_y) begin mY[i] = lim_y; mDir[i] = 1; end
                    else mY[i] += mSp[i];
                end else if (mY[i] < mSp[i]) begin mY[i] = 0; mDir[i] = 0; end
                else mY[i] -= mSp[i];
            end else if (mMode[i] == 2) begin
                if (mDir[i] == 0) begin
                    if (mX[i] < mSp[i]) begin mX[i] = 0; mDir[i] = 1; end
                    else mX[i] -= mSp[i];
                end else if (mX[i] + mSp[i] > lim_x) begin mX[i] = lim_x; mDir[i] = 0; end
                else mX[i] += mSp[i];
            end
`else
            if (mMode[i] == 1) mY[i] = (mY[i] + mSp[i] > lim_y) ? 0 : mY[i] + mSp[i];
            else if (mMode[i] == 2) mX[i] = (mX[i] < mSp[i]) ? lim_x : mX[i] - mSp[i];
`endif
        end
    endfunction

    task automatic driveCfg(input int idx, input int mode, input int x, input int y, input int sp);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_mode = 2'(mode);
        cfg_x = 10'(x); cfg_y = 9'(y); cfg_speed = SW'(sp);
        mMode[idx] = mode; mX[idx] = x; mY[idx] = y; mSp[idx] = sp; mDir[idx] = 0;
    endtask

    task automatic cfgWrite(input int idx, input int mode, input int x, input int y, input int sp);
        @(negedge clk) driveCfg(idx, mode, x, y, sp);
        @(negedge clk) cfg_we = 1'b0;
    endtask

    task automatic doTick();
        @(negedge clk) update = 1'b1;
        @(negedge clk) update = 1'b0;
        modelStep(-1);
    endtask

    task automatic tickWrite(input int idx, input int mode, input int x, input int y, input int sp);
        @(negedge clk) begin update = 1'b1; driveCfg(idx, mode, x, y, sp); end
        @(negedge clk) begin update = 1'b0; cfg_we = 1'b0; end
        modelStep(idx);
    endtask

    // Checks against the model; also against a hand-derived constant when expC >= 0.
    task automatic probe(input int px, input int py, input string name, input int expC);
        int eb;
        @(negedge clk) begin xCount = 10'(px); yCount = 10'(py); end
        @(negedge clk);
        eb = expBlocks(px, py);
        chk({name, ".blocks"}, 32'(blocks), eb);
        chk({name, ".any"}, 32'(any_block), (eb != 0));
        chk({name, ".idx"}, 32'(hit_idx), lowestBit(eb));
        if (expC >= 0) chk({name, ".const"}, 32'(blocks), expC);
    endtask

    initial begin
        rst = 1'b1; update = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_mode = '0;
        cfg_x = '0; cfg_y = '0; cfg_speed = '0; xCount = '0; yCount = '0;
        modelReset();
        repeat (3) @(negedge clk);
        chk("reset.outs", {blocks, any_block, hit_idx}, 0);
        rst = 1'b0;

        // Sparse frame sweep with every slot off.
        for (int y = 0; y < YM; y += 17)
            for (int x = 0; x < XM; x += 13) begin
                @(negedge clk) begin xCount = 10'(x); yCount = 10'(y); end
                @(negedge clk) chk("sweep", {blocks, any_block, hit_idx}, 0);
            end

        // Stationary slot 0 boundary vectors.
        tbl[0] = '{516, 101, 8'h01};
        tbl[1] = '{515, 101, 8'h00};
        tbl[2] = '{565, 101, 8'h00};
        tbl[3] = '{564, 149, 8'h01};
        tbl[4] = '{564, 150, 8'h00};
        tbl[5] = '{540, 100, 8'h00};
        cfgWrite(0, 3, 515, 100, 9);
        for (int i = 0; i < 6; i++) probe(tbl[i].px, tbl[i].py, "stat", int'(tbl[i].expB));
        repeat (10) doTick();
        for (int i = 0; i < 6; i++) probe(tbl[i].px, tbl[i].py, "stat10", int'(tbl[i].expB));

        // Vertical limit.
        cfgWrite(1, 1, 100, 428, 5);
        doTick();
`ifdef OBSTACLE_BOUNCE_EN
        probe(101, 431, "vert.clamp", 8'h02);
        doTick();
        probe(101, 426, "vert.back", 8'h02);
`else
        probe(101, 1, "vert.respawn", 8'h02);
`endif

        // Horizontal limit.
        cfgWrite(2, 2, 3, 300, 7);
        doTick();
`ifdef OBSTACLE_BOUNCE_EN
        probe(1, 301, "horz.clamp", 8'h04);
        doTick();
        probe(8, 301, "horz.back", 8'h04);
        probe(7, 301, "horz.edge", 8'h00);
`else
        probe(591, 301, "horz.respawn", 8'h04);
`endif

        // Held update gives one step only.
        @(negedge clk) update = 1'b1;
        repeat (20) @(negedge clk);
        update = 1'b0;
        modelStep(-1);
        probe(mX[2] + 1, 301, "hold.in", 8'h04);
        probe(mX[2], 301, "hold.edge", 8'h00);

        // Write and tick on the same edge: write wins.
        tickWrite(1, 1, 100, 75, 5);
        probe(101, 76, "wrtick.in", 8'h02);
        probe(101, 75, "wrtick.edge", 8'h00);

        // Overlap then reset.
        cfgWrite(3, 3, 200, 200, 0);
        cfgWrite(5, 3, 220, 220, 0);
        probe(230, 230, "overlap", 8'h28);
        chk("overlap.idx3", 32'(hit_idx), 3);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) chk("midrst", {blocks, any_block, hit_idx}, 0);
        rst = 1'b0;
        modelReset();
        probe(230, 230, "postrst", 8'h00);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            int r, j;
            r = $urandom_range(0, 9);
            j = $urandom_range(0, NB - 1);
            if (r < 2)
                cfgWrite(j, $urandom_range(0, 3), $urandom_range(0, 639), $urandom_range(0, 479),
                         $urandom_range(0, 15));
            else if (r == 2)
                tickWrite(j, $urandom_range(0, 3), $urandom_range(0, 639), $urandom_range(0, 479),
                          $urandom_range(0, 15));
            else if (r < 5)
                doTick();
            else begin
                int px, py;
                px = mX[j] + $urandom_range(0, 51);
                py = mY[j] + $urandom_range(0, 51);
                if (px > 1023) px = 1023;
                if (py > 1023) py = 1023;
                probe(px, py, "rand", -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
